regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port among NUM_REQ writeback requesters (index 0 = ALU, index 1 = load unit) using round-robin arbitration.
- Drives the select, data and enable of the register-file write-select mux through a one-cycle registered stage.
- Keeps a per-register busy scoreboard: set at issue, cleared when the write is accepted. The issue/hazard logic reads this scoreboard.

---
 rtl/rf_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 56 +++++
 rtl/regfile_wb_arbiter.sv | 112 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Register-file writeback package.
// Holds the default register-file geometry and the shared request types
// used by the writeback arbiter and by anything that builds requests for it.
package rf_pkg;

    localparam int REG_LOG    = 5;
    localparam int DATA_WIDTH = 64;
    localparam int NUM_REG    = 2 ** REG_LOG;

    typedef logic [REG_LOG-1:0]    reg_idx_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

    // One writeback request as seen by the arbiter.
    typedef struct packed {
        logic      valid;
        reg_idx_t  rd;
        reg_data_t data;
    } wb_req_t;

    // Register x0 is hard-wired; it never becomes busy and is never written.
    function automatic logic is_real_reg(input reg_idx_t r);
        return r != '0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
// Scans requesters starting one past the most recent grant and grants the
// first one that is requesting. The grant is purely combinational on req;
// last_grant only moves on an edge where a grant was issued.
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset; forces grant to zero and
//              returns last_grant to NUM_REQ-1 so requester 0 goes first
//   req        request vector, one bit per requester
//   grant      one-hot grant (all zero when nothing is requesting)
//   grant_idx  binary index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] last_grant_reg;
    logic [IDX_W-1:0] last_grant_next;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant           = '0;
        grant_idx       = '0;
        last_grant_next = last_grant_reg;
        cand            = '0;
        found           = 1'b0;
        // Offsets 1..NUM_REQ visit every requester once, ending on the
        // previous winner, so it has the lowest priority this cycle.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant_reg) + k) % NUM_REQ);
            if (!found && !reset && req[cand]) begin
                found           = 1'b1;
                grant[cand]     = 1'b1;
                grant_idx       = cand;
                last_grant_next = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with busy scoreboard.
// Shares the single register-file write port among NUM_REQ writeback
// requesters (0 = ALU, 1 = load unit) with round-robin arbitration, drives
// the write-select mux through one registered stage, and keeps a per-register
// busy scoreboard (set at issue, cleared when the write is accepted).
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   req_valid      per requester: a write is pending
//   req_rd         per requester: destination register
//   req_data       per requester: write data
//   req_ready      per requester: grant; write accepted when valid & ready
//   issue_valid    an instruction with a destination issues this cycle
//   issue_rd       destination of the issued instruction
//   wb_en          register-file write enable (registered)
//   wb_sel         register-file write select (registered)
//   wb_data        register-file write data (registered)
//   busy           scoreboard, bit r = write to register r outstanding
module regfile_wb_arbiter #(
    parameter int REG_LOG    = rf_pkg::REG_LOG,
    parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
    parameter int NUM_REQ    = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][REG_LOG-1:0]     req_rd,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic                                issue_valid,
    input  logic [REG_LOG-1:0]                  issue_rd,
    output logic                                wb_en,
    output logic [REG_LOG-1:0]                  wb_sel,
    output logic [DATA_WIDTH-1:0]               wb_data,
    output logic [2**REG_LOG-1:0]               busy
);

    localparam int NREG  = 2 ** REG_LOG;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  accept;
    logic                  acc_live;
    logic [REG_LOG-1:0]    acc_rd;
    logic [DATA_WIDTH-1:0] acc_data;

    logic                  wb_en_reg,   wb_en_next;
    logic [REG_LOG-1:0]    wb_sel_reg,  wb_sel_next;
    logic [DATA_WIDTH-1:0] wb_data_reg, wb_data_next;
    logic [NREG-1:0]       busy_reg,    busy_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;

    always_comb begin
        accept       = |grant;
        acc_rd       = req_rd[grant_idx];
        acc_data     = req_data[grant_idx];
        // A write to x0 still consumes the grant but never reaches the file.
        acc_live     = accept && (acc_rd != '0);
        wb_en_next   = acc_live;
        wb_sel_next  = accept ? acc_rd   : wb_sel_reg;
        wb_data_next = accept ? acc_data : wb_data_reg;
    end

    // Scoreboard: per-register set/clear. The clear happens at the accepting
    // edge; a same-edge set for the same register wins because it belongs to
    // a younger producer. x0 can never be set nor cleared.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            logic set_hit;
            logic clr_hit;
            assign set_hit = issue_valid && (issue_rd != '0) &&
                             (issue_rd == REG_LOG'(gi));
            assign clr_hit = acc_live && (acc_rd == REG_LOG'(gi));
            assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_en_reg   <= 1'b0;
            wb_sel_reg  <= '0;
            wb_data_reg <= '0;
            busy_reg    <= '0;
        end else begin
            wb_en_reg   <= wb_en_next;
            wb_sel_reg  <= wb_sel_next;
            wb_data_reg <= wb_data_next;
            busy_reg    <= busy_next;
        end
    end

    // A write accepted just before reset rises is still sitting in the output
    // register during the reset cycle; masking the enable discards it so the
    // register file never sees a write while reset is high.
    assign wb_en   = wb_en_reg && !reset;
    assign wb_sel  = wb_sel_reg;
    assign wb_data = wb_data_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios plus a randomized run,
// all compared against a behavioural model of grants, writeback and scoreboard.
module tb_regfile_wb_arbiter;
    import rf_pkg::*;

    localparam int NR = 2;

    logic                               clk = 1'b0;
    logic                               reset = 1'b1;
    logic [NR-1:0]                      req_valid = '0;
    logic [NR-1:0][REG_LOG-1:0]         req_rd = '0;
    logic [NR-1:0][DATA_WIDTH-1:0]      req_data = '0;
    logic [NR-1:0]                      req_ready;
    logic                               issue_valid = 1'b0;
    logic [REG_LOG-1:0]                 issue_rd = '0;
    logic                               wb_en;
    logic [REG_LOG-1:0]                 wb_sel;
    logic [DATA_WIDTH-1:0]              wb_data;
    logic [NUM_REG-1:0]                 busy;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .REG_LOG    (REG_LOG),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REQ    (NR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wb_en       (wb_en),
        .wb_sel      (wb_sel),
        .wb_data     (wb_data),
        .busy        (busy)
    );

    // Reference model state
    int          m_last = NR - 1;
    bit          m_en;
    bit [4:0]    m_sel;
    bit [63:0]   m_data;
    bit [31:0]   m_busy;
    int          n_cmp = 0;
    int          n_fail = 0;

    localparam wb_req_t IDLE = '0;

    function automatic wb_req_t mk(input bit v, input bit [4:0] rd, input bit [63:0] d);
        wb_req_t r;
        r.valid = v;
        r.rd    = rd;
        r.data  = d;
        return r;
    endfunction

    task automatic drive(input bit rst, input wb_req_t r0, input wb_req_t r1,
                         input bit iv, input bit [4:0] ird);
        reset       = rst;
        req_valid   = {r1.valid, r0.valid};
        req_rd[0]   = r0.rd;
        req_rd[1]   = r1.rd;
        req_data[0] = r0.data;
        req_data[1] = r1.data;
        issue_valid = iv;
        issue_rd    = ird;
    endtask

    // Who should win this cycle: first valid requester after the last winner.
    function automatic int model_grant();
        if (reset) return -1;
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (m_last + k) % NR;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int g);
        logic [NR-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Apply the effect of the upcoming clock edge to the model.
    task automatic model_commit();
        int g;
        g = model_grant();
        if (reset) begin
            m_en = 0; m_sel = 0; m_data = 0; m_busy = 0; m_last = NR - 1;
            return;
        end
        m_en = 0;
        if (g >= 0) begin
            m_last = g;
            m_sel  = req_rd[g];
            m_data = req_data[g];
            m_en   = (req_rd[g] != 0);
            if (req_rd[g] != 0) m_busy[req_rd[g]] = 1'b0;
        end
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    endtask

    task automatic apply_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(1'b1, IDLE, IDLE, 1'b0, 5'd0);
            model_commit();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(c < 2, mk(1, 5'd4, 64'h4), mk(1, 5'd6, 64'h6), 1'b1, 5'd9);
            #1;
            n_cmp++;
            if (c < 2 && (req_ready !== 2'b00 || wb_en !== 1'b0)) begin
                n_fail++;
                $display("FAIL reset_ready cyc=%0d got ready=%b wb_en=%b want ready=00 wb_en=0", c, req_ready, wb_en);
            end
            if (c == 2 && req_ready !== onehot(model_grant())) begin
                n_fail++;
                $display("FAIL reset_release_ready got=%b want=%b", req_ready, onehot(model_grant()));
            end
            model_commit();
            @(posedge clk); #1;
            n_cmp++;
            if ({wb_en, wb_sel, wb_data, busy} !== {m_en, m_sel, m_data, m_busy}) begin
                n_fail++;
                $display("FAIL reset_wb cyc=%0d got en=%b sel=%0d data=%h busy=%h want en=%b sel=%0d data=%h busy=%h",
                         c, wb_en, wb_sel, wb_data, busy, m_en, m_sel, m_data, m_busy);
            end
            $display("reset cyc=%0d ready=%b wb_en=%b wb_sel=%0d busy=%h", c, req_ready, wb_en, wb_sel, busy);
        end
        // After release the first grant went to requester 0 with rd=4.
        n_cmp++;
        if (wb_en !== 1'b1 || wb_sel !== 5'd4 || busy !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL reset_first_grant got en=%b sel=%0d busy=%h want en=1 sel=4 busy=00000200", wb_en, wb_sel, busy);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            case (c)
                0: drive(0, IDLE, IDLE, 1'b1, 5'd5);
                1: drive(0, mk(1, 5'd5, 64'hDEAD_BEEF), IDLE, 1'b0, 5'd0);
                default: drive(0, IDLE, IDLE, 1'b0, 5'd0);
            endcase
            #1;
            n_cmp++;
            if (req_ready !== onehot(model_grant())) begin
                n_fail++;
                $display("FAIL basic_ready cyc=%0d got=%b want=%b", c, req_ready, onehot(model_grant()));
            end
            model_commit();
            @(posedge clk); #1;
            n_cmp++;
            if ({wb_en, wb_sel, wb_data, busy} !== {m_en, m_sel, m_data, m_busy}) begin
                n_fail++;
                $display("FAIL basic_wb cyc=%0d got en=%b sel=%0d data=%h busy=%h want en=%b sel=%0d data=%h busy=%h",
                         c, wb_en, wb_sel, wb_data, busy, m_en, m_sel, m_data, m_busy);
            end
            n_cmp++;
            if ((c == 0 && busy[5] !== 1'b1) ||
                (c == 1 && (wb_en !== 1'b1 || wb_sel !== 5'd5 || wb_data !== 64'hDEAD_BEEF || busy[5] !== 1'b0))) begin
                n_fail++;
                $display("FAIL basic_const cyc=%0d got en=%b sel=%0d data=%h busy5=%b", c, wb_en, wb_sel, wb_data, busy[5]);
            end
            $display("basic cyc=%0d ready=%b wb_en=%b wb_sel=%0d wb_data=%h busy=%h", c, req_ready, wb_en, wb_sel, wb_data, busy);
        end
    endtask

    task automatic test_contention();
        int exp_g[4] = '{0, 1, 0, 1};
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(0, mk(1, 5'd1, 64'h11), mk(1, 5'd2, 64'h22), 1'b0, 5'd0);
            #1;
            n_cmp++;
            if (req_ready !== onehot(exp_g[c])) begin
                n_fail++;
                $display("FAIL contention_grant cyc=%0d got=%b want=%b", c, req_ready, onehot(exp_g[c]));
            end
            model_commit();
            @(posedge clk); #1;
            n_cmp++;
            if (wb_en !== 1'b1 || wb_sel !== 5'(exp_g[c] + 1) || wb_data !== 64'(8'h11 * (exp_g[c] + 1))) begin
                n_fail++;
                $display("FAIL contention_wb cyc=%0d got en=%b sel=%0d data=%h want en=1 sel=%0d",
                         c, wb_en, wb_sel, wb_data, exp_g[c] + 1);
            end
            $display("contention cyc=%0d ready=%b wb_en=%b wb_sel=%0d wb_data=%h", c, req_ready, wb_en, wb_sel, wb_data);
        end
    endtask

    task automatic test_x0();
        logic [31:0] busy_before;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (c == 0) drive(0, IDLE, mk(1, 5'd0, 64'hFF), 1'b1, 5'd12);
            else        drive(0, mk(1, 5'd1, 64'h11), mk(1, 5'd2, 64'h22), 1'b0, 5'd0);
            #1;
            busy_before = busy;
            n_cmp++;
            if (req_ready !== (c == 0 ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL x0_grant cyc=%0d got=%b want=%b", c, req_ready, (c == 0 ? 2'b10 : 2'b01));
            end
            model_commit();
            @(posedge clk); #1;
            n_cmp++;
            if ({wb_en, wb_sel, wb_data, busy} !== {m_en, m_sel, m_data, m_busy}) begin
                n_fail++;
                $display("FAIL x0_wb cyc=%0d got en=%b sel=%0d data=%h busy=%h want en=%b sel=%0d data=%h busy=%h",
                         c, wb_en, wb_sel, wb_data, busy, m_en, m_sel, m_data, m_busy);
            end
            if (c == 0) begin
                n_cmp++;
                if (wb_en !== 1'b0 || busy !== (busy_before | 32'h0000_1000)) begin
                    n_fail++;
                    $display("FAIL x0_noeffect got en=%b busy=%h want en=0 busy=%h", wb_en, busy, busy_before | 32'h0000_1000);
                end
            end
            $display("x0 cyc=%0d ready=%b wb_en=%b wb_sel=%0d busy=%h", c, req_ready, wb_en, wb_sel, busy);
        end
    endtask

    task automatic test_set_clear_same();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            case (c)
                0: drive(0, IDLE, IDLE, 1'b1, 5'd7);
                1: drive(0, mk(1, 5'd7, 64'h77), IDLE, 1'b1, 5'd7);
                default: drive(0, IDLE, IDLE, 1'b0, 5'd0);
            endcase
            #1;
            n_cmp++;
            if (req_ready !== onehot(model_grant())) begin
                n_fail++;
                $display("FAIL setclr_ready cyc=%0d got=%b want=%b", c, req_ready, onehot(model_grant()));
            end
            model_commit();
            @(posedge clk); #1;
            n_cmp++;
            if ({wb_en, wb_sel, wb_data, busy} !== {m_en, m_sel, m_data, m_busy}) begin
                n_fail++;
                $display("FAIL setclr_wb cyc=%0d got en=%b sel=%0d data=%h busy=%h want en=%b sel=%0d data=%h busy=%h",
                         c, wb_en, wb_sel, wb_data, busy, m_en, m_sel, m_data, m_busy);
            end
            if (c == 1) begin
                n_cmp++;
                if (busy[7] !== 1'b1 || wb_en !== 1'b1 || wb_sel !== 5'd7) begin
                    n_fail++;
                    $display("FAIL setclr_setwins got busy7=%b en=%b sel=%0d want busy7=1 en=1 sel=7", busy[7], wb_en, wb_sel);
                end
            end
            $display("setclr cyc=%0d ready=%b wb_en=%b wb_sel=%0d busy=%h", c, req_ready, wb_en, wb_sel, busy);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            case (c)
                0: drive(0, mk(1, 5'd3, 64'h33), IDLE, 1'b0, 5'd0);
                1: drive(1, mk(1, 5'd4, 64'h44), mk(1, 5'd8, 64'h88), 1'b1, 5'd9);
                default: drive(0, mk(1, 5'd4, 64'h44), mk(1, 5'd8, 64'h88), 1'b0, 5'd0);
            endcase
            #1;
            n_cmp++;
            if (req_ready !== onehot(model_grant()) || wb_en !== (m_en && !reset)) begin
                n_fail++;
                $display("FAIL resetmid_pre cyc=%0d got ready=%b en=%b want ready=%b en=%b",
                         c, req_ready, wb_en, onehot(model_grant()), m_en && !reset);
            end
            if (c == 1) begin
                n_cmp++;
                if (req_ready !== 2'b00 || wb_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL resetmid_discard got ready=%b en=%b want ready=00 en=0", req_ready, wb_en);
                end
            end
            model_commit();
            @(posedge clk); #1;
            n_cmp++;
            if ({wb_en, wb_sel, wb_data, busy} !== {m_en, m_sel, m_data, m_busy}) begin
                n_fail++;
                $display("FAIL resetmid_wb cyc=%0d got en=%b sel=%0d data=%h busy=%h want en=%b sel=%0d data=%h busy=%h",
                         c, wb_en, wb_sel, wb_data, busy, m_en, m_sel, m_data, m_busy);
            end
            if (c == 2) begin
                n_cmp++;
                if (wb_sel !== 5'd4 || busy !== 32'h0) begin
                    n_fail++;
                    $display("FAIL resetmid_priority got sel=%0d busy=%h want sel=4 busy=00000000", wb_sel, busy);
                end
            end
            $display("resetmid cyc=%0d ready=%b wb_en=%b wb_sel=%0d busy=%h", c, req_ready, wb_en, wb_sel, busy);
        end
    endtask

    task automatic test_req1_only();
        int exp_g[4] = '{1, 1, 1, 0};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c < 3) drive(0, IDLE, mk(1, 5'd9, 64'(c + 100)), 1'b0, 5'd0);
            else       drive(0, mk(1, 5'd10, 64'hA0), mk(1, 5'd11, 64'hB0), 1'b0, 5'd0);
            #1;
            n_cmp++;
            if (req_ready !== onehot(exp_g[c])) begin
                n_fail++;
                $display("FAIL req1only_grant cyc=%0d got=%b want=%b", c, req_ready, onehot(exp_g[c]));
            end
            model_commit();
            @(posedge clk); #1;
            n_cmp++;
            if ({wb_en, wb_sel, wb_data, busy} !== {m_en, m_sel, m_data, m_busy}) begin
                n_fail++;
                $display("FAIL req1only_wb cyc=%0d got en=%b sel=%0d data=%h busy=%h want en=%b sel=%0d data=%h busy=%h",
                         c, wb_en, wb_sel, wb_data, busy, m_en, m_sel, m_data, m_busy);
            end
            $display("req1only cyc=%0d ready=%b wb_en=%b wb_sel=%0d wb_data=%h", c, req_ready, wb_en, wb_sel, wb_data);
        end
    endtask

    task automatic test_random();
        wb_req_t cur[NR];
        logic [NR-1:0] granted;
        cur[0] = IDLE;
        cur[1] = IDLE;
        granted = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            // A pending request keeps rd/data stable until it is accepted.
            for (int i = 0; i < NR; i++) begin
                if (!cur[i].valid || granted[i])
                    cur[i] = mk($urandom_range(0, 9) < 6, 5'($urandom), {$urandom, $urandom});
            end
            drive(($urandom_range(0, 49) == 0), cur[0], cur[1], $urandom_range(0, 1) == 1, 5'($urandom));
            #1;
            granted = onehot(model_grant());
            n_cmp++;
            if (req_ready !== granted) begin
                n_fail++;
                $display("FAIL random_ready cyc=%0d got=%b want=%b", c, req_ready, granted);
            end
            if (reset) begin
                cur[0] = IDLE;
                cur[1] = IDLE;
            end
            model_commit();
            @(posedge clk); #1;
            n_cmp++;
            if ({wb_en, wb_sel, wb_data, busy} !== {m_en, m_sel, m_data, m_busy}) begin
                n_fail++;
                $display("FAIL random_wb cyc=%0d got en=%b sel=%0d data=%h busy=%h want en=%b sel=%0d data=%h busy=%h",
                         c, wb_en, wb_sel, wb_data, busy, m_en, m_sel, m_data, m_busy);
            end
            $display("random cyc=%0d rst=%b ready=%b wb_en=%b wb_sel=%0d busy=%h", c, reset, req_ready, wb_en, wb_sel, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_contention();
        test_x0();
        test_set_clear_same();
        test_reset_mid();
        test_req1_only();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
